// File: rtl/multi_ring_queue.sv
// Multi-queue command ring: NUM_Q circular queues sharing one storage array, one push port, one arbitrated registered pop port.
// Define RINGQ_STRICT_PRIO_EN for fixed lowest-qid-wins arbitration instead of round-robin.
module multi_ring_queue #(
  parameter int WIDTH     = 64,
  parameter int LOG_DEPTH = 4,
  parameter int NUM_Q     = 4,
  parameter int AF_THRESH = 12,
  localparam int QID_W    = $clog2(NUM_Q)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_valid,
  input  logic [QID_W-1:0]             push_qid,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         push_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [QID_W-1:0]             out_qid,
  input  logic [NUM_Q-1:0]             q_enable,
  input  logic                         flush,
  input  logic [QID_W-1:0]             flush_qid,
  output logic [NUM_Q-1:0]             q_empty,
  output logic [NUM_Q-1:0]             q_full,
  output logic [NUM_Q-1:0]             q_afull,
  output logic [NUM_Q*(LOG_DEPTH+1)-1:0] q_count
);

  localparam int CW     = LOG_DEPTH + 1;
  localparam int DEPTH  = 1 << LOG_DEPTH;
  localparam int ADDR_W = QID_W + LOG_DEPTH;
  localparam logic [CW-1:0]  AF_LVL = CW'(AF_THRESH);
  localparam logic [QID_W:0] NQ_LVL = (QID_W + 1)'(NUM_Q);

  logic [CW-1:0]    head_r [NUM_Q];
  logic [CW-1:0]    tail_r [NUM_Q];
  logic [CW-1:0]    count_s [NUM_Q];
  logic [WIDTH-1:0] mem_r [NUM_Q*DEPTH];

  logic [NUM_Q-1:0] empty_s, full_s, afull_s, flush_sel_s, elig_s;
  logic             qid_ok_s, push_ready_s, push_fire_s, load_en_s, found_s, pop_s;
  logic [QID_W-1:0] grant_s;
  logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [QID_W-1:0] out_qid_r;

  // Per-queue occupancy flags; the wrap bit distinguishes full from empty.
  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      count_s[i]     = tail_r[i] - head_r[i];
      empty_s[i]     = (head_r[i] == tail_r[i]);
      full_s[i]      = (head_r[i][LOG_DEPTH] != tail_r[i][LOG_DEPTH]) &&
                       (head_r[i][LOG_DEPTH-1:0] == tail_r[i][LOG_DEPTH-1:0]);
      afull_s[i]     = (count_s[i] >= AF_LVL);
      flush_sel_s[i] = flush && (flush_qid == QID_W'(i));
      elig_s[i]      = !empty_s[i] && q_enable[i] && !flush_sel_s[i];
    end
  end

  // Push acceptance is independent of push_valid so producers may wait on it.
  always_comb begin
    qid_ok_s     = ({1'b0, push_qid} < NQ_LVL);
    push_ready_s = qid_ok_s && !full_s[push_qid] && !(flush && (flush_qid == push_qid));
    push_fire_s  = push_valid && push_ready_s;
    load_en_s    = !out_valid_r || out_ready;
    pop_s        = load_en_s && found_s;
    wr_addr_s    = {push_qid, tail_r[push_qid][LOG_DEPTH-1:0]};
    rd_addr_s    = {grant_s, head_r[grant_s][LOG_DEPTH-1:0]};
  end

`ifdef RINGQ_STRICT_PRIO_EN
  // Fixed priority: scanning downward leaves the lowest eligible qid as winner.
  always_comb begin
    found_s = 1'b0;
    grant_s = {QID_W{1'b0}};
    for (int k = NUM_Q - 1; k >= 0; k--) begin
      grant_s = elig_s[k] ? QID_W'(k) : grant_s;
      found_s = found_s | elig_s[k];
    end
  end
`else
  logic [QID_W-1:0] rr_r;

  // Round-robin search starting one past the last granted queue.
  always_comb begin
    logic [QID_W-1:0] idx;
    idx     = {QID_W{1'b0}};
    found_s = 1'b0;
    grant_s = {QID_W{1'b0}};
    for (int k = 1; k <= NUM_Q; k++) begin
      idx     = QID_W'((int'(rr_r) + k) % NUM_Q);
      grant_s = (!found_s && elig_s[idx]) ? idx : grant_s;
      found_s = found_s | elig_s[idx];
    end
  end

  // Round-robin pointer advances only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r <= QID_W'(NUM_Q - 1);
    end else if (pop_s) begin
      rr_r <= grant_s;
    end
  end
`endif

  // Head/tail pointers; a flushed queue never sees a push or pop that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_Q; i++) begin
        head_r[i] <= {CW{1'b0}};
        tail_r[i] <= {CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_Q; i++) begin
        if (flush_sel_s[i]) begin
          head_r[i] <= tail_r[i];
        end else if (pop_s && (grant_s == QID_W'(i))) begin
          head_r[i] <= head_r[i] + CW'(1);
        end
        if (push_fire_s && (push_qid == QID_W'(i))) begin
          tail_r[i] <= tail_r[i] + CW'(1);
        end
      end
    end
  end

  // Shared command storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_fire_s) begin
      mem_r[wr_addr_s] <= push_data;
    end
  end

  // Output register: reload when empty or consumed, otherwise hold stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_qid_r   <= {QID_W{1'b0}};
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= mem_r[rd_addr_s];
      out_qid_r   <= grant_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Pack per-queue counts onto the flat status bus.
  always_comb begin
    q_count = {(NUM_Q*CW){1'b0}};
    for (int i = 0; i < NUM_Q; i++) begin
      q_count[i*CW +: CW] = count_s[i];
    end
  end

  assign push_ready = push_ready_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_qid    = out_qid_r;
  assign q_empty    = empty_s;
  assign q_full     = full_s;
  assign q_afull    = afull_s;

endmodule

// File: tb/tb_multi_ring_queue.sv
// Self-checking bench for multi_ring_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_multi_ring_queue;
  localparam int WIDTH = 64, LOG_DEPTH = 4, NUM_Q = 4, AF_THRESH = 12;
  localparam int QID_W = 2, CW = LOG_DEPTH + 1, DEPTH = 16;

  logic clk, rst_n, push_valid, push_ready, out_valid, out_ready, flush;
  logic [QID_W-1:0] push_qid, out_qid, flush_qid;
  logic [WIDTH-1:0] push_data, out_data;
  logic [NUM_Q-1:0] q_enable, q_empty, q_full, q_afull;
  logic [NUM_Q*CW-1:0] q_count;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: one FIFO per queue plus the output register
  logic [WIDTH-1:0] m_q [NUM_Q][$];
  logic             m_ov;
  logic [WIDTH-1:0] m_od;
  logic [QID_W-1:0] m_oq;
  int               m_rr;

  multi_ring_queue #(.WIDTH(WIDTH), .LOG_DEPTH(LOG_DEPTH), .NUM_Q(NUM_Q), .AF_THRESH(AF_THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_qid(push_qid), .push_data(push_data),
    .push_ready(push_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_qid(out_qid), .q_enable(q_enable), .flush(flush), .flush_qid(flush_qid),
    .q_empty(q_empty), .q_full(q_full), .q_afull(q_afull), .q_count(q_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cnt(int i);
    return q_count[i*CW +: CW];
  endfunction

  function automatic bit m_elig(int i);
    return (m_q[i].size() > 0) && q_enable[i] && !(flush && (int'(flush_qid) == i));
  endfunction

  function automatic bit m_push_ready();
    return (m_q[push_qid].size() < DEPTH) && !(flush && (flush_qid == push_qid));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NUM_Q; i++) m_q[i].delete();
    m_ov = 1'b0; m_od = '0; m_oq = '0; m_rr = NUM_Q - 1;
  endtask

  // one clock: decide model transfers from pre-edge inputs, advance, sample 1 time unit later
  task automatic tick();
    bit pr, ld;
    int g, i;
    pr = m_push_ready();
    ld = !m_ov || out_ready;
    g = -1;
    if (ld) begin
`ifdef RINGQ_STRICT_PRIO_EN
      for (int k = 0; k < NUM_Q; k++) if (g < 0 && m_elig(k)) g = k;
`else
      for (int k = 1; k <= NUM_Q; k++) begin
        i = (m_rr + k) % NUM_Q;
        if (g < 0 && m_elig(i)) g = i;
      end
`endif
    end
    @(posedge clk);
    if (g >= 0) begin
      m_od = m_q[g].pop_front(); m_oq = QID_W'(g); m_ov = 1'b1; m_rr = g;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (flush) m_q[flush_qid].delete();
    if (push_valid && pr) m_q[push_qid].push_back(push_data);
    #1;
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0; push_qid = '0; push_data = '0; out_ready = 1'b0; flush = 1'b0; flush_qid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    q_enable = 4'hf;
    rst_n = 1'b0;
    #1;
    m_reset();
    rst_n = 1'b1;
  endtask

  task automatic push_n(int q, int n, int base);
    for (int j = 0; j < n; j++) begin
      push_valid = 1'b1; push_qid = QID_W'(q); push_data = 64'(base + j);
      tick();
    end
    push_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 64'd0 || out_qid !== 2'd0) begin n_fail++; $display("FAIL rst_out_data: got %0h/%0d want 0/0", out_data, out_qid); end
    n_cmp++; if (q_empty !== 4'hf || q_count !== 20'd0) begin n_fail++; $display("FAIL rst_empty: got %0h/%0h want f/0", q_empty, q_count); end
    rst_n = 1'b1;
    q_enable = 4'h1; out_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      push_n(0, 1, 16'h100 + j);
      push_n(1, 1, 16'h200 + j);
    end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'h100) begin n_fail++; $display("FAIL mid_traffic_out: got %0b/%0h want 1/100", out_valid, out_data); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || q_empty !== 4'hf) begin n_fail++; $display("FAIL async_reset: got %0b/%0h want 0/f", out_valid, q_empty); end
    m_reset();
    #1 rst_n = 1'b1;
    q_enable = 4'h0;
    tick();
    n_cmp++; if (q_count !== 20'd0) begin n_fail++; $display("FAIL post_reset_count: got %0h want 0", q_count); end
    push_n(1, 1, 16'hA1);
    push_n(0, 1, 16'hA0);
    q_enable = 4'hf; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_qid !== 2'd0 || out_data !== 64'hA0) begin n_fail++; $display("FAIL first_grant: got %0b/%0d/%0h want 1/0/a0", out_valid, out_qid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_qid !== 2'd1 || out_data !== 64'hA1) begin n_fail++; $display("FAIL second_grant: got %0b/%0d/%0h want 1/1/a1", out_valid, out_qid, out_data); end
  endtask

  task automatic test_fill_drain();
    int k;
    do_reset();
    q_enable = 4'b1011;
    for (int i = 0; i < DEPTH; i++) begin
      push_valid = 1'b1; push_qid = 2'd2; push_data = 64'(i);
      #1;
      n_cmp++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %0b want 1", i, push_ready); end
      tick();
      n_cmp++; if (cnt(2) !== CW'(i + 1) || q_afull[2] !== ((i + 1) >= AF_THRESH) || q_full[2] !== ((i + 1) == DEPTH))
        begin n_fail++; $display("FAIL fill_status[%0d]: got cnt %0d af %0b f %0b", i, cnt(2), q_afull[2], q_full[2]); end
    end
    push_data = 64'd16;
    #1;
    n_cmp++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", push_ready); end
    tick();
    push_valid = 1'b0;
    n_cmp++; if (cnt(2) !== 5'd16) begin n_fail++; $display("FAIL full_no_overwrite: got %0d want 16", cnt(2)); end
    q_enable = 4'hf; out_ready = 1'b1; k = 0;
    for (int c = 0; c < 60 && k < DEPTH; c++) begin
      tick();
      if (out_valid) begin
        n_cmp++; if (out_data !== 64'(k) || out_qid !== 2'd2) begin n_fail++; $display("FAIL drain[%0d]: got %0h/%0d want %0h/2", k, out_data, out_qid, k); end
        k++;
      end
    end
    n_cmp++; if (k != DEPTH) begin n_fail++; $display("FAIL drain_count: got %0d want 16", k); end
  endtask

  task automatic test_interleave();
    int exp_q [9];
    int jq [NUM_Q];
    do_reset();
    q_enable = 4'h0;
    for (int q = 0; q < NUM_Q; q++) begin
      jq[q] = 0;
      if (q != 2) push_n(q, 3, q * 256);
    end
    for (int s = 0; s < 9; s++) begin
`ifdef RINGQ_STRICT_PRIO_EN
      exp_q[s] = (s < 3) ? 0 : (s < 6) ? 1 : 3;
`else
      exp_q[s] = (s % 3 == 2) ? 3 : s % 3;
`endif
    end
    q_enable = 4'hf; out_ready = 1'b1;
    tick();
    for (int s = 0; s < 9; s++) begin
      n_cmp++; if (out_valid !== 1'b1 || int'(out_qid) != exp_q[s] || out_data !== 64'(exp_q[s] * 256 + jq[exp_q[s]]))
        begin n_fail++; $display("FAIL interleave[%0d]: got %0b/%0d/%0h want 1/%0d", s, out_valid, out_qid, out_data, exp_q[s]); end
      jq[exp_q[s]]++;
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL interleave_end: got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    q_enable = 4'h0;
    push_n(0, 4, 16'hB0);
    q_enable = 4'h1;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'hB0 || cnt(0) !== 5'd3)
        begin n_fail++; $display("FAIL backpressure[%0d]: got %0b/%0h/%0d want 1/b0/3", c, out_valid, out_data, cnt(0)); end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 64'hB1 || cnt(0) !== 5'd2) begin n_fail++; $display("FAIL bp_release: got %0h/%0d want b1/2", out_data, cnt(0)); end
  endtask

  task automatic test_flush();
    do_reset();
    q_enable = 4'h0;
    push_n(1, 8, 16'hC0);
    q_enable = 4'h2;
    tick();
    n_cmp++; if (out_data !== 64'hC0 || cnt(1) !== 5'd7) begin n_fail++; $display("FAIL pre_flush: got %0h/%0d want c0/7", out_data, cnt(1)); end
    flush = 1'b1; flush_qid = 2'd1;
    push_valid = 1'b1; push_qid = 2'd1; push_data = 64'hCF;
    #1;
    n_cmp++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL flush_push_ready: got %0b want 0", push_ready); end
    tick();
    flush = 1'b0; push_valid = 1'b0;
    n_cmp++; if (cnt(1) !== 5'd0 || q_empty[1] !== 1'b1) begin n_fail++; $display("FAIL flush_count: got %0d/%0b want 0/1", cnt(1), q_empty[1]); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 64'hC0) begin n_fail++; $display("FAIL flush_held: got %0b/%0h want 1/c0", out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: got %0b want 0", out_valid); end
  endtask

  task automatic test_wrap();
    int sent, got;
    sent = 0; got = 0;
    do_reset();
    for (int c = 0; c < 400 && got < 40; c++) begin
      push_qid = 2'd0; push_valid = (sent < 40); push_data = 64'(1000 + sent);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== 64'(1000 + got)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0d want %0d", got, out_data, 1000 + got); end
        got++;
      end
      if (push_valid && m_push_ready()) sent++;
      tick();
      n_cmp++; if (cnt(0) > 5'd16 || int'(cnt(0)) != m_q[0].size()) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", cnt(0), m_q[0].size()); end
    end
    push_valid = 1'b0;
    n_cmp++; if (got != 40) begin n_fail++; $display("FAIL wrap_total: got %0d want 40", got); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_qid = QID_W'($urandom_range(0, NUM_Q - 1));
      push_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) q_enable = 4'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      flush_qid = QID_W'($urandom_range(0, NUM_Q - 1));
      #1;
      n_cmp++; if (push_ready !== m_push_ready()) begin n_fail++; $display("FAIL rnd_push_ready[%0d]: got %0b want %0b", c, push_ready, m_push_ready()); end
      tick();
      n_cmp++; if (out_valid !== m_ov || (m_ov && (out_data !== m_od || out_qid !== m_oq)))
        begin n_fail++; $display("FAIL rnd_out[%0d]: got %0b/%0h/%0d want %0b/%0h/%0d", c, out_valid, out_data, out_qid, m_ov, m_od, m_oq); end
      for (int q = 0; q < NUM_Q; q++) begin
        n_cmp++; if (int'(cnt(q)) != m_q[q].size() || q_empty[q] !== (m_q[q].size() == 0) ||
                     q_full[q] !== (m_q[q].size() == DEPTH) || q_afull[q] !== (m_q[q].size() >= AF_THRESH))
          begin n_fail++; $display("FAIL rnd_status[%0d] q%0d: got cnt %0d want %0d", c, q, cnt(q), m_q[q].size()); end
      end
    end
    idle_inputs();
  endtask

`ifdef RINGQ_STRICT_PRIO_EN
  task automatic test_strict_prio();
    int seen;
    seen = 0;
    do_reset();
    q_enable = 4'h0;
    push_n(3, 4, 16'h300);
    push_n(0, 4, 16'h000);
    q_enable = 4'hf; out_ready = 1'b1;
    for (int c = 0; c < 30 && seen < 8; c++) begin
      tick();
      if (out_valid) begin
        n_cmp++; if (out_qid !== ((seen < 4) ? 2'd0 : 2'd3)) begin n_fail++; $display("FAIL strict[%0d]: got %0d", seen, out_qid); end
        seen++;
      end
    end
    n_cmp++; if (seen != 8) begin n_fail++; $display("FAIL strict_count: got %0d want 8", seen); end
  endtask
`endif

  initial begin
    idle_inputs();
    q_enable = 4'hf;
    rst_n = 1'b0;
    m_reset();
    #12;
    test_reset();
    test_fill_drain();
    test_interleave();
    test_backpressure();
    test_flush();
    test_wrap();
    test_random();
`ifdef RINGQ_STRICT_PRIO_EN
    test_strict_prio();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_ring_queue.md
Name: multi_ring_queue

Overview:
- Next-generation command ring: NUM_Q independent circular queues share one storage array, with one push port (queue selected by qid) and one arbitrated pop port.
- Sits between the command fetcher and command decode; each queue is one hardware submission ring.
- Adds per-queue flush, an almost-full watermark, per-queue enable masking, round-robin arbitration and a registered output stage.

Parameters:
- WIDTH, 64, command width in bits.
- LOG_DEPTH, 4, per-queue depth = 2^LOG_DEPTH.
- NUM_Q, 4, number of queues; legal range 2..16.
- AF_THRESH, 12, q_afull asserts when count >= AF_THRESH.
- QID_W (localparam), $clog2(NUM_Q), queue-id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- push_valid  in  1  producer has a command
- push_qid  in  QID_W  target queue
- push_data  in  WIDTH  command
- push_ready  out  1  push accepted this cycle when valid&ready
- out_valid  out  1  output register holds a command
- out_ready  in  1  consumer takes the output
- out_data  out  WIDTH  dequeued command
- out_qid  out  QID_W  source queue of out_data
- q_enable  in  NUM_Q  per-queue arbitration enable
- flush  in  1  discard all stored entries of flush_qid
- flush_qid  in  QID_W  queue to flush
- q_empty  out  NUM_Q  per-queue empty
- q_full  out  NUM_Q  per-queue full
- q_afull  out  NUM_Q  per-queue count >= AF_THRESH
- q_count  out  NUM_Q*(LOG_DEPTH+1)  packed per-queue occupancy; queue i at bits [i*(LOG_DEPTH+1) +: LOG_DEPTH+1]

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All heads and tails 0.
  - out_valid=0, out_data=0, out_qid=0.
  - RR pointer = NUM_Q-1, so queue 0 wins first.
  - Storage is not reset.
- Per queue, head and tail are LOG_DEPTH+1 bits (wrap bit).
  - empty: head==tail.
  - full: wrap bits differ and indices are equal.
  - count = tail-head, modulo 2^(LOG_DEPTH+1).
  - Count covers storage only; the output register is excluded.
- Storage address = {qid, index}; NUM_Q*2^LOG_DEPTH entries.
- push_ready is combinational, = !q_full[push_qid] && push_qid<NUM_Q && !(flush && flush_qid==push_qid).
  - On accept: write storage, tail[push_qid]++.
  - push_ready must not depend on push_valid.
- Output stage: load_en = !out_valid || out_ready.
  - If load_en, the arbiter picks one eligible queue (!q_empty && q_enable, not being flushed this cycle).
  - On a pick: out_data <= mem[head], out_qid <= qid, out_valid <= 1, head++.
  - With no eligible queue: out_valid <= 0 when out_ready, else hold.
- Arbitration: round-robin. Search starts at RR pointer+1, modulo NUM_Q; the RR pointer updates to the granted qid only on a grant.
- Latency:
  - A push accepted at edge E into an idle block gives out_valid=1 after edge E+1.
  - Sustained throughput is 1 command/cycle.
- Same-queue push and dequeue in one cycle: both happen; count unchanged.
  - A push into an empty queue is not visible to the arbiter until the next cycle.
- Full queue: push_ready=0, no overwrite. Empty queue: never granted.
- Flush:
  - Sets head[flush_qid] <= tail[flush_qid] in one cycle.
  - That queue is not granted and does not accept pushes in the flush cycle.
  - An entry already in the output register is retained and delivered.
- Disabling a queue via q_enable keeps its contents and does not affect the output register.
- out_data/out_qid are held stable while out_valid && !out_ready.

Optional Feature:
- Macro: RINGQ_STRICT_PRIO_EN.
- Defined: fixed priority, lowest qid wins; no RR pointer is implemented.
- Undefined: round-robin as above.

Test Plan:
- Reset mid-traffic: queues 0/1 half full, out_valid=1, rst_n low asynchronously → immediately out_valid=0 and all q_empty=1; after release, counts are 0 and RR grants queue 0 first.
- Fill queue 2 with 16 pushes → q_full[2]=1, q_afull[2]=1 from count 12, 17th push sees push_ready=0; then drain → data 0..15 in order, out_qid=2.
- Interleaving: queues 0, 1, 3 each hold 3 entries, out_ready=1 → out_qid sequence 0,1,3,0,1,3,0,1,3 with no bubbles.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data stable and heads unchanged.
- Flush q1 (count 7) while the output register holds a q1 entry, plus a simultaneous push to q1 → q1 count=0, push_ready=0 that cycle, held entry still delivered.
- Wrap: 40 push/pop pairs on q0 with a random out_ready pattern → in-order data across pointer wrap and count never exceeds 16.
- With RINGQ_STRICT_PRIO_EN: q0 and q3 both non-empty → all q0 entries drain before any q3 entry.
